// File: rtl/seg7_decode38_if.sv
// Handshake bundle between the 7-segment receiver and its downstream consumer.
// The master side drives the display pattern, enable and ready; the slave returns the decoded result.
interface seg7_decode38_if;
    logic       en;
    logic [6:0] seg_in;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] y;
    logic [7:0] x;
    logic       flag;
    logic       err;
    logic [7:0] err_cnt;

    modport master (
        output en, seg_in, out_ready,
        input  out_valid, y, x, flag, err, err_cnt
    );

    modport slave (
        input  en, seg_in, out_ready,
        output out_valid, y, x, flag, err, err_cnt
    );
endinterface

// File: rtl/seg7_decode38.sv
// Receives an active-low 7-segment digit (0-7), waits for the pattern to settle, then delivers
// the 3-bit code and its one-hot form once over a valid/ready handshake, counting unknown patterns.
module seg7_decode38 #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input logic            clk,
    input logic            rst_n,
    seg7_decode38_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD, WAIT_CHG} state_t;

    localparam logic [6:0]       BLANK     = 7'h7F;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] STABLE_TH = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    logic [6:0]       seg_q;
    logic [6:0]       lat;
    logic [CNT_W-1:0] stab_cnt;
    logic             stable;
    logic             dec_ok;
    logic [2:0]       dec_y;

    // Returns {recognised, digit}; blank and unknown patterns both report recognised=0.
    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'h01:   decode = 4'b1_000;
            7'h4F:   decode = 4'b1_001;
            7'h12:   decode = 4'b1_010;
            7'h06:   decode = 4'b1_011;
            7'h4C:   decode = 4'b1_100;
            7'h24:   decode = 4'b1_101;
            7'h20:   decode = 4'b1_110;
            7'h0F:   decode = 4'b1_111;
            default: decode = 4'b0_000;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign stable          = (stab_cnt >= STABLE_TH);
    assign {dec_ok, dec_y} = decode(seg_q);

    // Sampler: runs in every state so the stability count is already valid when SETTLE is entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q    <= BLANK;
            stab_cnt <= '0;
        end else begin
            seg_q <= bus.seg_in;
            if (bus.seg_in == seg_q) begin
                if (stab_cnt != CNT_MAX)
                    stab_cnt <= stab_cnt + 1'b1;
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            lat           <= BLANK;
            bus.out_valid <= 1'b0;
            bus.y         <= 3'd0;
            bus.x         <= 8'd0;
            bus.flag      <= 1'b0;
            bus.err       <= 1'b0;
            bus.err_cnt   <= 8'd0;
        end else if (!bus.en) begin
            // Disable wins over a pending handshake; the error count survives.
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.y         <= 3'd0;
            bus.x         <= 8'd0;
            bus.flag      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= SETTLE;
                SETTLE: begin
                    if (stable && seg_q != BLANK) begin
                        lat           <= seg_q;
                        state         <= HOLD;
                        bus.out_valid <= 1'b1;
                        if (dec_ok) begin
                            bus.y    <= dec_y;
                            bus.x    <= 8'd1 << dec_y;
                            bus.flag <= 1'b1;
                            bus.err  <= 1'b0;
                        end else begin
                            bus.y       <= 3'd0;
                            bus.x       <= 8'd0;
                            bus.flag    <= 1'b0;
                            bus.err     <= 1'b1;
                            bus.err_cnt <= sat_inc8(bus.err_cnt);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= WAIT_CHG;
                    end
                end
                WAIT_CHG: begin
                    if (seg_q != lat)
                        state <= SETTLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_decode38.sv
// Randomised and directed bench for seg7_decode38 against a run-length based reference model.
module tb_seg7_decode38;
    localparam int S = 4;
    localparam int P_OFF = 0, P_LOOK = 1, P_HELD = 2, P_WAIT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    seg7_decode38_if bus();

    seg7_decode38 #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [6:0] digits [8] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F};

    // Reference model: tracks how long the input has been held, and what was last emitted.
    int         phase;
    int         run;
    int         d;
    logic [6:0] prev, last;
    logic       m_valid, m_flag, m_err, was_stable;
    logic [2:0] m_y;
    logic [7:0] m_x, m_cnt;

    function automatic int digit_of(input logic [6:0] s);
        for (int i = 0; i < 8; i++)
            if (digits[i] == s) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            phase = P_OFF; run = 1; prev = 7'h7F; last = 7'h7F;
            m_valid = 0; m_y = 0; m_x = 0; m_flag = 0; m_err = 0; m_cnt = 0;
        end else begin
            was_stable = (run >= S);
            if (!bus.en) begin
                phase = P_OFF; m_valid = 0; m_y = 0; m_x = 0; m_flag = 0; m_err = 0;
            end else if (phase == P_OFF) begin
                phase = P_LOOK;
            end else if (phase == P_LOOK) begin
                if (was_stable && prev != 7'h7F) begin
                    last = prev; phase = P_HELD; m_valid = 1;
                    d = digit_of(prev);
                    if (d >= 0) begin
                        m_y = 3'(d); m_x = 8'd1 << d; m_flag = 1; m_err = 0;
                    end else begin
                        m_y = 0; m_x = 0; m_flag = 0; m_err = 1;
                        m_cnt = (m_cnt == 8'd255) ? m_cnt : m_cnt + 8'd1;
                    end
                end
            end else if (phase == P_HELD) begin
                if (m_valid && bus.out_ready) begin m_valid = 0; phase = P_WAIT; end
            end else begin
                if (prev != last) phase = P_LOOK;
            end
            if (bus.seg_in == prev) run++; else run = 1;
            prev = bus.seg_in;
        end
    end

    function automatic logic [21:0] obs();
        return {bus.out_valid, bus.y, bus.x, bus.flag, bus.err, bus.err_cnt};
    endfunction

    function automatic logic [21:0] expv();
        return {m_valid, m_y, m_x, m_flag, m_err, m_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps until out_valid is seen; n = edges taken, or -1 if the budget expired.
    task automatic wait_valid(input int lim, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.out_valid && n < lim);
        if (!bus.out_valid) n = -1;
    endtask

    task automatic test_reset();
        rst_n = 0; bus.en = 0; bus.seg_in = 7'h7F; bus.out_ready = 0;
        tick(); tick();
        tests++;
        if (obs() !== 22'h0) begin fails++; $display("FAIL reset_outputs: got %h want 000000", obs()); end
        tests++;
        if (obs() !== expv()) begin fails++; $display("FAIL reset_model: got %h want %h", obs(), expv()); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_basic();
        int n, extra;
        bus.en = 1; bus.seg_in = 7'h12; bus.out_ready = 1;
        wait_valid(20, n);
        tests++;
        if (n != 5) begin fails++; $display("FAIL basic_latency: got %0d edges want 5", n); end
        tests++;
        if ({bus.y, bus.x, bus.flag, bus.err} !== {3'd2, 8'h04, 1'b1, 1'b0})
            begin fails++; $display("FAIL basic_result: got y=%0d x=%h f=%b e=%b want y=2 x=04 f=1 e=0", bus.y, bus.x, bus.flag, bus.err); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (bus.out_valid) extra++; end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL basic_no_repeat: got %0d valid cycles want 0", extra); end
    endtask

    task automatic test_hold();
        int n, bad;
        bus.seg_in = 7'h0F; bus.out_ready = 0;
        wait_valid(20, n);
        tests++;
        if (n < 0) begin fails++; $display("FAIL hold_timeout: got no valid want valid"); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) bus.seg_in = 7'h01;
            tick();
            if ({bus.out_valid, bus.y, bus.x} !== {1'b1, 3'd7, 8'h80}) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL hold_frozen: got %0d bad cycles want 0", bad); end
        bus.out_ready = 1;
        tick();
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL hold_accept: got valid=%b want 0", bus.out_valid); end
        wait_valid(20, n);
        tests++;
        if (n < 0 || {bus.y, bus.x, bus.flag} !== {3'd0, 8'h01, 1'b1})
            begin fails++; $display("FAIL hold_next: got n=%0d y=%0d x=%h want y=0 x=01", n, bus.y, bus.x); end
    endtask

    task automatic test_glitch();
        int n, seen;
        bus.out_ready = 1;
        seen = 0;
        for (int i = 0; i < 21; i++) begin
            bus.seg_in = (i % 3 == 2) ? 7'h4F : 7'h24;
            tick();
            if (bus.out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL glitch_suppress: got %0d valid cycles want 0", seen); end
        bus.seg_in = 7'h24;
        wait_valid(20, n);
        tests++;
        if (n != 5 || bus.y !== 3'd5 || bus.x !== 8'h20)
            begin fails++; $display("FAIL glitch_recover: got n=%0d y=%0d x=%h want n=5 y=5 x=20", n, bus.y, bus.x); end
    endtask

    task automatic test_invalid();
        int n, bad;
        logic [6:0] inv, prev_inv;
        rst_n = 0; tick(); rst_n = 1;
        bus.en = 1; bus.out_ready = 1; bus.seg_in = 7'h55;
        wait_valid(20, n);
        tests++;
        if (n < 0 || {bus.err, bus.flag, bus.y, bus.x, bus.err_cnt} !== {1'b1, 1'b0, 3'd0, 8'h00, 8'd1})
            begin fails++; $display("FAIL invalid_first: got err=%b flag=%b y=%0d x=%h cnt=%0d want 1 0 0 00 1", bus.err, bus.flag, bus.y, bus.x, bus.err_cnt); end
        prev_inv = 7'h55;
        bad = 0;
        for (int a = 0; a < 300; a++) begin
            do inv = 7'($urandom_range(0, 127));
            while (digit_of(inv) >= 0 || inv == 7'h7F || inv == prev_inv);
            prev_inv = inv;
            bus.seg_in = inv;
            for (int c = 0; c < 7; c++) begin tick(); if (obs() !== expv()) bad++; end
            bus.seg_in = digits[$urandom_range(0, 7)];
            for (int c = 0; c < 7; c++) begin tick(); if (obs() !== expv()) bad++; end
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL invalid_model: got %0d mismatching cycles want 0", bad); end
        tests++;
        if (bus.err_cnt !== 8'd255) begin fails++; $display("FAIL invalid_saturate: got %0d want 255", bus.err_cnt); end
    endtask

    task automatic test_blank_en();
        int n, seen;
        bus.out_ready = 1; bus.seg_in = 7'h7F;
        seen = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (bus.out_valid) seen++; end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL blank_no_result: got %0d valid cycles want 0", seen); end
        bus.out_ready = 0; bus.seg_in = 7'h06;
        wait_valid(20, n);
        tests++;
        if (n < 0 || bus.y !== 3'd3) begin fails++; $display("FAIL en_setup: got n=%0d y=%0d want y=3", n, bus.y); end
        bus.en = 0; bus.out_ready = 1;
        tick();
        tests++;
        if ({bus.out_valid, bus.y, bus.x, bus.flag, bus.err, bus.err_cnt} !== {1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'd255})
            begin fails++; $display("FAIL en_drop: got %h want 0000ff", obs()); end
        bus.en = 1;
    endtask

    task automatic test_reset_mid();
        int n;
        rst_n = 0; tick(); rst_n = 1;
        bus.en = 1; bus.out_ready = 1; bus.seg_in = 7'h55;
        for (int i = 0; i < 7; i++) tick();
        bus.seg_in = 7'h5A;
        for (int i = 0; i < 7; i++) tick();
        bus.out_ready = 0; bus.seg_in = 7'h33;
        wait_valid(20, n);
        tick(); tick();
        tests++;
        if (n < 0 || bus.out_valid !== 1'b1 || bus.err_cnt !== 8'd3)
            begin fails++; $display("FAIL midrst_setup: got valid=%b cnt=%0d want 1 3", bus.out_valid, bus.err_cnt); end
        rst_n = 0; tick(); rst_n = 1;
        tests++;
        if (obs() !== 22'h0) begin fails++; $display("FAIL midrst_clear: got %h want 000000", obs()); end
        bus.seg_in = 7'h4C; bus.out_ready = 1;
        wait_valid(20, n);
        tests++;
        if (n < 0 || {bus.y, bus.x, bus.flag} !== {3'd4, 8'h10, 1'b1})
            begin fails++; $display("FAIL midrst_redecode: got y=%0d x=%h want y=4 x=10", bus.y, bus.x); end
    endtask

    task automatic test_random();
        int hold, pick;
        hold = 0;
        rst_n = 0; tick(); rst_n = 1;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                pick = $urandom_range(0, 99);
                if (pick < 60)      bus.seg_in = digits[$urandom_range(0, 7)];
                else if (pick < 75) bus.seg_in = 7'h7F;
                else                bus.seg_in = 7'($urandom_range(0, 127));
                hold = $urandom_range(1, 8);
            end
            hold--;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.en        = ($urandom_range(0, 59) != 0);
            rst_n         = ($urandom_range(0, 799) != 0);
            tick();
            tests++;
            if (obs() !== expv()) begin fails++; $display("FAIL random_c%0d: got %h want %h", c, obs(), expv()); end
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_glitch();
        test_invalid();
        test_blank_en();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg7_decode38.md
Name: seg7_decode38

Overview:
- Receive side of the 8-3 encoder / 7-segment display path: takes an active-low 7-segment pattern (digits 0-7) and recovers the 3-bit code and the 8-bit one-hot vector.
- A stability filter accepts a pattern only after it has held steady for a programmable number of clocks.
- Each decoded value is delivered once via a valid/ready handshake. Unrecognised patterns are flagged and counted.
- Sits between a display bus or loopback and downstream logic such as LEDs or a checker.

Parameters:
- STABLE_CYCLES, 4, number of consecutive sampled edges seg_in must be unchanged before it is decoded; range 2..15.
- CNT_W, 4, stability counter width; must satisfy STABLE_CYCLES < 2^CNT_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  decode enable.
- seg_in  input  7  active-low segments, bit6=a ... bit0=g.
- out_ready  input  1  downstream accepts the current result.
- out_valid  output  1  result held on y/x/flag/err.
- y  output  3  decoded digit.
- x  output  8  one-hot of y (x[y]=1); 0 when flag=0.
- flag  output  1  result is a recognised digit.
- err  output  1  result is an unrecognised non-blank pattern.
- err_cnt  output  8  count of err results, saturating at 255.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - out_valid, y, x, flag, err, err_cnt = 0.
  - seg_q = 7'h7F; stab_cnt = 0; lat = 7'h7F.
- Sampler, runs every edge regardless of state:
  - seg_q <= seg_in.
  - If seg_in==seg_q, stab_cnt <= stab_cnt+1 (saturating); otherwise stab_cnt <= 0.
  - stable = (stab_cnt >= STABLE_CYCLES-1).
- Decode table (seg_q -> y):
  - 7'h01->0, 7'h4F->1, 7'h12->2, 7'h06->3, 7'h4C->4, 7'h24->5, 7'h20->6, 7'h0F->7.
  - 7'h7F = blank.
  - Anything else = invalid.
- FSM states: IDLE, SETTLE, HOLD, WAIT_CHG.
  - IDLE: en=1 -> SETTLE.
  - SETTLE, when stable and seg_q is not blank:
    - lat <= seg_q; state -> HOLD; out_valid <= 1.
    - Recognised pattern: y = decoded value, x = one-hot, flag=1, err=0.
    - Invalid pattern: y=0, x=0, flag=0, err=1, err_cnt++ (saturating at 255).
  - SETTLE, stable but blank: stay in SETTLE; no result is produced.
  - HOLD:
    - y/x/flag/err/out_valid stay frozen; seg_in changes are ignored.
    - out_valid & out_ready at an edge -> out_valid <= 0, state -> WAIT_CHG. y/x/flag/err are retained.
  - WAIT_CHG: seg_q != lat -> SETTLE. The same pattern held continuously is never re-emitted.
- Latency:
  - seg_in held at STABLE_CYCLES consecutive edges k..k+S-1.
  - out_valid rises at edge k+S; seg_in at edge k+S is don't-care.
  - Result is accepted at the first edge with out_ready=1 while out_valid=1; minimum occupancy is 1 cycle.
- en=0 at any edge, in any state except reset:
  - Next state IDLE.
  - out_valid, y, x, flag, err cleared to 0; err_cnt retained.
  - en=0 has priority over a simultaneous handshake; that result is dropped.
- Reset mid-operation: all state and outputs return to reset values at that edge, including err_cnt.
- A glitch (one-cycle change) during SETTLE restarts the stability count; no partial result is emitted.

Test Plan:
- Reset, en=1, seg_in=7'h12 held, out_ready=1, STABLE_CYCLES=4 -> out_valid high for 1 cycle at the 5th edge after seg_in applied; y=2, x=8'h04, flag=1, err=0; out_valid does not reassert while 7'h12 persists.
- seg_in=7'h0F, out_ready=0 for 6 cycles, seg_in changed to 7'h01 during HOLD -> y=7, x=8'h80 held stable the whole time; after out_ready=1, next result is y=0, x=8'h01.
- seg_in=7'h24 with a 1-cycle glitch to 7'h4F every 3 cycles -> out_valid never asserts; once glitches stop, y=5 appears after 4 stable edges.
- seg_in=7'h55 held -> out_valid=1, err=1, flag=0, y=0, x=0, err_cnt=1; repeat 300 distinct invalid/valid alternations -> err_cnt saturates at 255.
- seg_in=7'h7F held -> no out_valid. en dropped during HOLD with out_ready=1 on the same edge -> out_valid=0, y=0, x=0, flag=0 next cycle.
- rst_n=0 for one edge while in HOLD with err_cnt=3 -> all outputs 0 and err_cnt=0; re-enabled decode of 7'h4C yields y=4, x=8'h10.
